regfile_wr_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32×64 register file. Two writeback sources (requester 0: ALU, requester 1: memory/load) each push register writes through a valid/ready handshake into a private 2-entry FIFO. The arbiter grants one write per cycle and drives the register file's single write port (`RegWrite`, `WriteRegister`, `WriteData`) from registered outputs. Writes to X31 are consumed but never asserted on the port.

---
 rtl/regfile_wr_arbiter_if.sv | 48 ++++
 rtl/regfile_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_if
//
// Purpose: bundles the two writeback request channels and the register-file
// write port of regfile_wr_arbiter.
//
// Signals:
//   req0_valid/req0_reg/req0_data/req0_ready : requester 0 (ALU) channel
//   req1_valid/req1_reg/req1_data/req1_ready : requester 1 (memory/load) channel
//   RegWrite/WriteRegister/WriteData         : register-file write port
//   idle                                     : nothing queued, no write on port
//
// Modports:
//   master : the requester side (drives valid/reg/data, observes everything else)
//   slave  : the arbiter side
// -----------------------------------------------------------------------------
interface regfile_wr_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [63:0] req0_data;
    logic        req0_ready;

    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [63:0] req1_data;
    logic        req1_ready;

    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        idle;

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        input  RegWrite, WriteRegister, WriteData, idle
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        output RegWrite, WriteRegister, WriteData, idle
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose: write-port arbiter/sequencer for the 32x64 register file. Each of
// two writeback sources pushes writes into a private DEPTH-entry FIFO; one
// head entry is popped per cycle and registered onto the single write port.
// Writes to X31 are popped (and count as a grant) but never raise RegWrite.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; empties both FIFOs and clears the
//           write port immediately
//   bus   : regfile_wr_arbiter_if.slave (request channels, write port, idle)
//
// Parameters:
//   DEPTH : entries per requester FIFO, power of 2, >= 2
//
// Configuration macro:
//   RF_ARB_RR_EN defined   -> round-robin tie-break (requester != last wins)
//   RF_ARB_RR_EN undefined -> fixed priority, requester 0 wins ties
//
// Handshake: an entry is accepted on a rising edge where valid && ready.
// ready depends only on the FIFO count and reset (never on valid), there is
// no pass-through when full, and valid need not be held after acceptance.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    regfile_wr_arbiter_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Per-requester storage and bookkeeping, index k = requester number.
    logic [4:0]    reg_mem  [2][DEPTH];
    logic [63:0]   data_mem [2][DEPTH];
    logic [PW-1:0] wr_ptr   [2];
    logic [PW-1:0] rd_ptr   [2];
    logic [CW-1:0] count    [2];

    logic [1:0]    in_valid;
    logic [4:0]    in_reg  [2];
    logic [63:0]   in_data [2];

    logic [1:0]    full;
    logic [1:0]    not_empty;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;

    logic          tie_sel;
    logic          gnt_any;
    logic          gnt_sel;
    logic [4:0]    head_reg;
    logic [63:0]   head_data;

    logic          last_q;
    logic          rw_q;
    logic [4:0]    wreg_q;
    logic [63:0]   wdata_q;

    assign in_valid   = {bus.req1_valid, bus.req0_valid};
    assign in_reg[0]  = bus.req0_reg;
    assign in_reg[1]  = bus.req1_reg;
    assign in_data[0] = bus.req0_data;
    assign in_data[1] = bus.req1_data;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            full[k]      = (count[k] == FULL_CNT);
            not_empty[k] = (count[k] != '0);
            ready[k]     = !full[k] && !reset;
            push[k]      = in_valid[k] && ready[k];
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

`ifdef RF_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    assign tie_sel = ~last_q;
`else
    // Fixed priority: requester 0 wins every tie; last_q is still tracked.
    assign tie_sel = 1'b0;
    logic unused_last;
    assign unused_last = last_q;
`endif

    always_comb begin
        gnt_any = |not_empty;
        gnt_sel = (&not_empty) ? tie_sel : not_empty[1];
        pop     = 2'b00;
        if (gnt_any) begin
            pop = gnt_sel ? 2'b10 : 2'b01;
        end
        head_reg  = gnt_sel ? reg_mem[1][rd_ptr[1]]  : reg_mem[0][rd_ptr[0]];
        head_data = gnt_sel ? data_mem[1][rd_ptr[1]] : data_mem[0][rd_ptr[0]];
    end

    // FIFO payload storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                reg_mem[k][wr_ptr[k]]  <= in_reg[k];
                data_mem[k][wr_ptr[k]] <= in_data[k];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PW'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + CW'(1);
                    2'b01:   count[k] <= count[k] - CW'(1);
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // Write port: the granted head is registered; X31 is popped but muted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            last_q  <= gnt_sel;
            rw_q    <= (head_reg != 5'd31);
            wreg_q  <= head_reg;
            wdata_q <= head_data;
        end else begin
            rw_q    <= 1'b0;
        end
    end

    assign bus.RegWrite      = rw_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData     = wdata_q;
    assign bus.idle          = !not_empty[0] && !not_empty[1] && !rw_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Bench for regfile_wr_arbiter. A queue-based reference model (one queue per
// requester, arbitration rule applied to the queue heads) predicts every
// output at each falling edge; an issue-order queue tracks the writes the
// register file must see. Honors RF_ARB_RR_EN for the tie-break rule.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus();

    regfile_wr_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [68:0] mq0[$];
    logic [68:0] mq1[$];
    logic [68:0] exp_q[$];
    logic [4:0]  obs_regs[$];
    bit          m_last;
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [63:0] m_wdata;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        m_last  = 1'b1;
        m_rw    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
    endfunction

    // One rising edge of the model: grant from the heads present before the
    // edge, then append whatever the requesters handed over at that edge.
    function automatic void model_edge(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                                       input logic v1, input logic [4:0] r1, input logic [63:0] d1,
                                       output bit a0, output bit a1);
        bit          rdy0, rdy1, sel;
        logic [68:0] e;
        rdy0 = (mq0.size() < DEPTH);
        rdy1 = (mq1.size() < DEPTH);
        if (mq0.size() != 0 || mq1.size() != 0) begin
            if (mq0.size() != 0 && mq1.size() != 0) begin
`ifdef RF_ARB_RR_EN
                sel = !m_last;
`else
                sel = 1'b0;
`endif
            end else begin
                sel = (mq1.size() != 0);
            end
            e       = sel ? mq1.pop_front() : mq0.pop_front();
            m_last  = sel;
            m_wreg  = e[68:64];
            m_wdata = e[63:0];
            m_rw    = (e[68:64] != 5'd31);
            if (m_rw) exp_q.push_back(e);
        end else begin
            m_rw = 1'b0;
        end
        a0 = v0 && rdy0;
        a1 = v1 && rdy1;
        if (a0) mq0.push_back({r0, d0});
        if (a1) mq1.push_back({r1, d1});
    endfunction

    function automatic void check_outputs();
        logic [68:0] e;
        check("rw",     bus.RegWrite, m_rw);
        check("wreg",   bus.WriteRegister, m_wreg);
        check("wdata",  bus.WriteData, m_wdata);
        check("idle",   bus.idle, (mq0.size() == 0 && mq1.size() == 0 && !m_rw));
        check("ready0", bus.req0_ready, (!reset && mq0.size() < DEPTH));
        check("ready1", bus.req1_ready, (!reset && mq1.size() < DEPTH));
        if (bus.RegWrite === 1'b1) begin
            obs_regs.push_back(bus.WriteRegister);
            check("sb_expected_write", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_reg",  bus.WriteRegister, e[68:64]);
                check("sb_data", bus.WriteData, e[63:0]);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [63:0] d1,
                        output bit a0, output bit a1);
        @(negedge clk);
        check_outputs();
        bus.req0_valid = v0;
        bus.req0_reg   = r0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_reg   = r1;
        bus.req1_data  = d1;
        model_edge(v0, r0, d0, v1, r1, d1, a0, a1);
    endtask

    task automatic idle_cycles(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, a0, a1);
    endtask

    // Both requesters offer 4 writes (regs 0-3 and 10-13), holding valid until taken.
    task automatic contention();
        int i0, i1;
        bit a0, a1;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
            step(i0 < 4, 5'(i0), {$urandom, $urandom},
                 i1 < 4, 5'(10 + i1), {$urandom, $urandom}, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
        end
        check("cont_all_accepted", 5'(i0 + i1), 5'd8);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit   a0, a1;
        bit   stall_seen;
        int   i0, i1;
        int   exp_order[8];
        logic [4:0] r0, r1;

        // ---- reset / idle ----
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b0;
        #1;
        check("rel_ready0", bus.req0_ready, 1'b1);
        check("rel_ready1", bus.req1_ready, 1'b1);
        check("rel_idle",   bus.idle, 1'b1);
        idle_cycles(2);

        // ---- single write latency ----
        step(1'b1, 5'd5, 64'h0000010204080001, 1'b0, 5'd0, 64'd0, a0, a1);
        check("lat_accept", a0, 1'b1);
        idle_cycles(2);
        check("lat_rw",   bus.RegWrite, 1'b1);
        check("lat_reg",  bus.WriteRegister, 5'd5);
        check("lat_data", bus.WriteData, 64'h0000010204080001);
        idle_cycles(1);
        check("lat_rw_off", bus.RegWrite, 1'b0);

        // ---- X31 suppression ----
        obs_regs.delete();
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hA0, a0, a1);
        idle_cycles(3);
        check("x31_no_write", obs_regs.size(), 0);
        check("x31_idle",     bus.idle, 1'b1);
        check("x31_ready1",   bus.req1_ready, 1'b1);

        // ---- backpressure: req0 holds 4 writes, req1 streams 6 ----
        i0 = 0; i1 = 0; stall_seen = 1'b0;
        for (int c = 0; c < 30 && (i0 < 4 || i1 < 6); c++) begin
            step(i0 < 4, 5'(1 + i0), {$urandom, $urandom},
                 i1 < 6, 5'(20 + i1), {$urandom, $urandom}, a0, a1);
            if (bus.req0_ready === 1'b0 || bus.req1_ready === 1'b0) stall_seen = 1'b1;
            if (a0) i0++;
            if (a1) i1++;
        end
        idle_cycles(8);
        check("bp_stall_seen", stall_seen, 1'b1);
        check("bp_drained",    exp_q.size(), 0);

        // ---- contention: issue order ----
`ifdef RF_ARB_RR_EN
        exp_order = '{0, 10, 1, 11, 2, 12, 3, 13};
`else
        exp_order = '{0, 1, 2, 3, 10, 11, 12, 13};
`endif
        obs_regs.delete();
        contention();
        idle_cycles(8);
        check("cont_count", obs_regs.size(), 8);
        for (int i = 0; i < 8 && i < obs_regs.size(); i++) begin
            check($sformatf("cont_order[%0d]", i), obs_regs[i], 5'(exp_order[i]));
        end

        // ---- randomized traffic (valid may drop, some X31) ----
        for (int c = 0; c < 200; c++) begin
            r0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            r1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            step(1'($urandom_range(0, 1)), r0, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), r1, {$urandom, $urandom}, a0, a1);
        end
        idle_cycles(6);
        check("rand_drained", exp_q.size(), 0);

        // ---- asynchronous reset mid-stream ----
        step(1'b1, 5'd7, 64'h7777, 1'b1, 5'd8, 64'h8888, a0, a1);
        step(1'b1, 5'd9, 64'h9999, 1'b1, 5'd6, 64'h6666, a0, a1);
        @(negedge clk);
        check_outputs();
        check("pre_rst_rw", bus.RegWrite, 1'b1);
        #2;
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("rst_async_rw",     bus.RegWrite, 1'b0);
        check("rst_async_ready0", bus.req0_ready, 1'b0);
        check("rst_async_ready1", bus.req1_ready, 1'b0);
        check("rst_async_wreg",   bus.WriteRegister, 5'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        obs_regs.delete();
        idle_cycles(5);
        check("post_rst_no_write", obs_regs.size(), 0);
        check("post_rst_idle",     bus.idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
